// File: rtl/flac_pkg.sv
// flac_pkg: shared state encoding and FIXED subframe constants
package flac_pkg;
  localparam int DATA_W_DEF = 16;
  localparam int BS_W_DEF = 16;
  localparam int FIXED_ORDER_MIN = 0;
  localparam int FIXED_ORDER_MAX = 4;
  typedef enum logic [2:0] {IDLE, CLEAR, WARMUP, RESIDUAL, DRAIN, DONE} state_t;
endpackage

// File: rtl/latency_pipe.sv
// latency_pipe: delays a valid strobe by DEPTH cycles to align with decoder output
module latency_pipe #(
  parameter int DEPTH = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tail
);
  logic [DEPTH-1:0] pipe;
  if (DEPTH == 1) begin : g_one
    always_ff @(posedge clk) pipe <= rst ? 1'b0 : en;
  end else begin : g_many
    always_ff @(posedge clk) pipe <= rst ? '0 : {pipe[DEPTH-2:0], en};
  end
  assign tail = pipe[DEPTH-1];
endmodule

// File: rtl/fixed_subframe_sequencer.sv
// fixed_subframe_sequencer: steps an external FixedDecoder through one FIXED subframe
module fixed_subframe_sequencer
  import flac_pkg::*;
#(
  parameter int DATA_W      = DATA_W_DEF,
  parameter int BS_W        = BS_W_DEF,
  parameter int DEC_LATENCY = 1,
  parameter int MAX_ORDER   = FIXED_ORDER_MAX
) (
  input  logic              iClock,
  input  logic              iReset,
  input  logic              iStart,
  input  logic [7:0]        iOrder,
  input  logic [BS_W-1:0]   iBlockSize,
  input  logic [DATA_W-1:0] iSample,
  input  logic              iSampleValid,
  output logic              oSampleReady,
  output logic              oDecReset,
  output logic              oDecEnable,
  output logic [7:0]        oDecOrder,
  output logic [DATA_W-1:0] oDecSample,
  input  logic [DATA_W-1:0] iDecData,
  output logic [DATA_W-1:0] oData,
  output logic              oDataValid,
  output logic              oBusy,
  output logic              oDone,
  output logic              oError
);
  state_t state;
  logic [7:0] order;
  logic [BS_W-1:0] bs;
  logic [BS_W:0] in_cnt, out_cnt, in_next, bs_x;
  logic xfer, tail, bad_cmd;
  assign xfer = iSampleValid & oSampleReady;
  assign in_next = in_cnt + 1'b1;
  assign bs_x = {1'b0, bs};
  // counters are one bit wider than the block size so a full block never wraps
  assign bad_cmd = iOrder > 8'(MAX_ORDER) || iBlockSize == '0 ||
                   {1'b0, iBlockSize} < (BS_W+1)'(iOrder);
  latency_pipe #(.DEPTH(DEC_LATENCY)) u_pipe (
    .clk (iClock),
    .rst (iReset),
    .en  (oDecEnable),
    .tail(tail)
  );
  always_ff @(posedge iClock) begin
    if (iReset) begin
      state        <= IDLE;
      order        <= '0;
      bs           <= '0;
      in_cnt       <= '0;
      out_cnt      <= '0;
      oSampleReady <= 1'b0;
      oDecReset    <= 1'b0;
      oDecEnable   <= 1'b0;
      oDecOrder    <= '0;
      oDecSample   <= '0;
      oData        <= '0;
      oDataValid   <= 1'b0;
      oBusy        <= 1'b0;
      oDone        <= 1'b0;
      oError       <= 1'b0;
    end else begin
      oDecEnable <= xfer;
      oDecSample <= xfer ? iSample : oDecSample;
      oDataValid <= tail;
      oData      <= tail ? iDecData : oData;
      out_cnt    <= tail ? out_cnt + 1'b1 : out_cnt;
      oDecReset  <= 1'b0;
      oDone      <= 1'b0;
      oError     <= 1'b0;
      case (state)
        IDLE: if (iStart) begin
          order <= iOrder;
          bs    <= iBlockSize;
          if (bad_cmd) oError <= 1'b1;
          else begin
            state     <= CLEAR;
            oDecReset <= 1'b1;
            oDecOrder <= iOrder;
            oBusy     <= 1'b1;
            in_cnt    <= '0;
            out_cnt   <= '0;
          end
        end
        CLEAR: begin
          state        <= order == '0 ? RESIDUAL : WARMUP;
          oSampleReady <= 1'b1;
        end
        WARMUP, RESIDUAL: if (xfer) begin
          in_cnt <= in_next;
          if (in_next == bs_x) begin
            state        <= DRAIN;
            oSampleReady <= 1'b0;
          end else if (state == WARMUP && in_next == (BS_W+1)'(order)) state <= RESIDUAL;
        end
        DRAIN: if (out_cnt == bs_x) begin
          state <= DONE;
          oDone <= 1'b1;
        end
        DONE: begin
          state     <= IDLE;
          oBusy     <= 1'b0;
          oDecOrder <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fixed_subframe_sequencer.sv
// tb_fixed_subframe_sequencer: directed checks of the sequencer driving a FixedDecoder model
module tb_fixed_subframe_sequencer;
  localparam int DW = 16;
  localparam int BW = 16;
  logic clk = 0, rst = 1, start = 0, sample_valid = 0;
  logic [7:0] order = '0;
  logic [BW-1:0] block = '0;
  logic signed [DW-1:0] sample = '0;
  logic sample_ready, dec_reset, dec_enable, data_valid, busy, done, error;
  logic [7:0] dec_order;
  logic signed [DW-1:0] dec_sample, dec_data, dec_next, data;
  logic signed [DW-1:0] h1, h2, h3, h4;
  int dcnt;
  int n_cmp = 0, n_err = 0;
  int cyc = 0, done_cnt = 0, err_cnt = 0, rst_cnt = 0, busy_cnt = 0, bad_en = 0;
  int outs[$], xfer_cyc[$], valid_cyc[$];
  bit xfer_prev = 0;

  fixed_subframe_sequencer #(.DATA_W(DW), .BS_W(BW), .DEC_LATENCY(1), .MAX_ORDER(4)) dut (
    .iClock(clk), .iReset(rst), .iStart(start), .iOrder(order), .iBlockSize(block),
    .iSample(sample), .iSampleValid(sample_valid), .oSampleReady(sample_ready),
    .oDecReset(dec_reset), .oDecEnable(dec_enable), .oDecOrder(dec_order),
    .oDecSample(dec_sample), .iDecData(dec_data), .oData(data), .oDataValid(data_valid),
    .oBusy(busy), .oDone(done), .oError(error)
  );

  always #5 clk = ~clk;

  // FixedDecoder stand-in: warm-up passes through, then polynomial prediction plus residual
  function automatic int fixed_pred(int o, int r, int a, int b, int c, int d);
    case (o)
      0: return r;
      1: return r + a;
      2: return r + 2*a - b;
      3: return r + 3*a - 3*b + c;
      default: return r + 4*a - 6*b + 4*c - d;
    endcase
  endfunction
  always_comb dec_next = (dcnt < int'(dec_order)) ? dec_sample :
    16'(fixed_pred(int'(dec_order), int'(dec_sample), int'(h1), int'(h2), int'(h3), int'(h4)));
  always @(posedge clk) begin
    if (dec_reset) begin
      h1 <= '0; h2 <= '0; h3 <= '0; h4 <= '0; dcnt <= 0; dec_data <= '0;
    end else if (dec_enable) begin
      dec_data <= dec_next;
      h1 <= dec_next; h2 <= h1; h3 <= h2; h4 <= h3;
      dcnt <= dcnt + 1;
    end
  end

  always @(negedge clk) begin
    cyc++;
    if (data_valid) begin outs.push_back(int'(data)); valid_cyc.push_back(cyc); end
    if (sample_valid && sample_ready) xfer_cyc.push_back(cyc);
    if (dec_enable && !xfer_prev) bad_en++;
    xfer_prev = sample_valid && sample_ready;
    done_cnt += int'(done);
    err_cnt  += int'(error);
    rst_cnt  += int'(dec_reset);
    busy_cnt += int'(busy);
  end

  task automatic check(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic start_cmd(input int o, input int b);
    start = 1; order = 8'(o); block = BW'(b);
    tick;
    start = 0;
  endtask

  task automatic feed(input int s, input bit stall);
    bit ok = 0;
    int t = 0;
    if (stall) begin sample_valid = 0; tick; end
    sample = DW'(s); sample_valid = 1;
    while (!ok && t < 100) begin
      @(negedge clk); ok = sample_ready;
      tick; t++;
    end
    if (!ok) check("feed_timeout", 0, 1);
    sample_valid = 0;
  endtask

  task automatic wait_idle;
    int t = 0;
    while (busy && t < 300) begin tick; t++; end
    if (busy) check("idle_timeout", 1, 0);
  endtask

  function automatic int out_at(int i);
    return (i < outs.size()) ? outs[i] : -99999;
  endfunction

  task automatic check_outs(input string tag, input int base, input int e0, e1, e2, e3);
    check({tag, "_n"}, outs.size() - base, 4);
    check({tag, "_d0"}, out_at(base), e0);
    check({tag, "_d1"}, out_at(base + 1), e1);
    check({tag, "_d2"}, out_at(base + 2), e2);
    check({tag, "_d3"}, out_at(base + 3), e3);
  endtask

  task automatic illegal(input string tag, input int o, input int b);
    int be = err_cnt, br = rst_cnt, bb = busy_cnt;
    start_cmd(o, b);
    repeat (4) tick;
    check({tag, "_err"}, err_cnt - be, 1);
    check({tag, "_clr"}, rst_cnt - br, 0);
    check({tag, "_busy"}, busy_cnt - bb, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int bo, bd, bx, bv, be, bb;
    int s[4] = '{10, -7, -4, 8};
    repeat (3) tick;
    check("reset_outs", int'(|{sample_ready, dec_reset, dec_enable, dec_order, dec_sample,
                              data, data_valid, busy, done, error}), 0);
    rst = 0;
    tick;
    // order 0: residuals are the samples
    bo = outs.size(); bd = done_cnt; bx = xfer_cyc.size(); bv = valid_cyc.size();
    start_cmd(0, 4);
    foreach (s[i]) feed(s[i], 0);
    wait_idle;
    check_outs("ord0", bo, 10, -7, -4, 8);
    check("ord0_done", done_cnt - bd, 1);
    check("ord0_latency", (valid_cyc.size() > bv && xfer_cyc.size() > bx) ?
          valid_cyc[bv] - xfer_cyc[bx] : -1, 3);
    // order 1
    bo = outs.size(); bd = done_cnt;
    start_cmd(1, 4);
    foreach (s[i]) feed(s[i], 0);
    wait_idle;
    check_outs("ord1", bo, 10, 3, -1, 7);
    check("ord1_done", done_cnt - bd, 1);
    // order 2 with upstream valid toggling
    bo = outs.size(); bd = done_cnt;
    start_cmd(2, 4);
    foreach (s[i]) feed(s[i], 1);
    wait_idle;
    check_outs("ord2", bo, 10, -7, -28, -41);
    check("ord2_done", done_cnt - bd, 1);
    check("ord2_enable_gated", bad_en, 0);
    // rejected commands
    illegal("bad_order", 5, 8);
    illegal("short_block", 3, 2);
    illegal("zero_block", 0, 0);
    // reset mid-subframe
    bd = done_cnt;
    start_cmd(3, 8);
    feed(10, 0);
    feed(-7, 0);
    rst = 1;
    tick;
    check("midreset_outs", int'(|{sample_ready, dec_reset, dec_enable, dec_order, dec_sample,
                                 data, data_valid, busy, done, error}), 0);
    rst = 0;
    repeat (20) tick;
    check("midreset_nodone", done_cnt - bd, 0);
    bo = outs.size(); bd = done_cnt;
    start_cmd(0, 4);
    foreach (s[i]) feed(s[i], 0);
    wait_idle;
    check_outs("after_reset", bo, 10, -7, -4, 8);
    check("after_reset_done", done_cnt - bd, 1);
    // iStart during RESIDUAL and during DONE
    bo = outs.size(); bd = done_cnt; be = err_cnt;
    start_cmd(0, 4);
    feed(s[0], 0);
    feed(s[1], 0);
    start_cmd(5, 0);
    feed(s[2], 0);
    feed(s[3], 0);
    begin
      int t = 0;
      do begin @(negedge clk); t++; end while (!done && t < 100);
      if (!done) check("done_timeout", 0, 1);
    end
    #1 start = 1; order = 8'd0; block = BW'(1);
    @(posedge clk); #1 start = 0;
    bb = busy_cnt;
    repeat (6) tick;
    check("ignore_busy", busy_cnt - bb, 0);
    check("ignore_err", err_cnt - be, 0);
    check("ignore_done", done_cnt - bd, 1);
    check_outs("ignore", bo, 10, -7, -4, 8);
    check("enable_gated_all", bad_en, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
